// File: rtl/fft_pkg.sv
// Shared widths, complex types and twiddle table for the 32-point radix-2 FFT.
package fft_pkg;

   localparam int N  = 32;
   localparam int DW = 16;
   localparam int TW = 16;
   localparam int TF = 14;
   localparam int OW = DW + TW + 2;

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic signed [OW-1:0] re;
      logic signed [OW-1:0] im;
   } cplx_out_t;

   typedef struct packed {
      logic signed [TW-1:0] re;
      logic signed [TW-1:0] im;
   } tw_t;

   // W_k = round(16384*cos(2*pi*k/N)) - j*round(16384*sin(2*pi*k/N)), S(2,14)
   function automatic tw_t twiddle(input logic [3:0] k);
      logic signed [TW-1:0] c;
      logic signed [TW-1:0] s;
      tw_t w;
      case (k)
         4'd0:    {c, s} = {16'sd16384, 16'sd0};
         4'd1:    {c, s} = {16'sd16069, 16'sd3196};
         4'd2:    {c, s} = {16'sd15137, 16'sd6270};
         4'd3:    {c, s} = {16'sd13623, 16'sd9102};
         4'd4:    {c, s} = {16'sd11585, 16'sd11585};
         4'd5:    {c, s} = {16'sd9102, 16'sd13623};
         4'd6:    {c, s} = {16'sd6270, 16'sd15137};
         4'd7:    {c, s} = {16'sd3196, 16'sd16069};
         4'd8:    {c, s} = {16'sd0, 16'sd16384};
         4'd9:    {c, s} = {-16'sd3196, 16'sd16069};
         4'd10:   {c, s} = {-16'sd6270, 16'sd15137};
         4'd11:   {c, s} = {-16'sd9102, 16'sd13623};
         4'd12:   {c, s} = {-16'sd11585, 16'sd11585};
         4'd13:   {c, s} = {-16'sd13623, 16'sd9102};
         4'd14:   {c, s} = {-16'sd15137, 16'sd6270};
         default: {c, s} = {-16'sd16069, 16'sd3196};
      endcase
      w.re = c;
      w.im = -s;
      return w;
   endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// 16-entry twiddle ROM with a registered read; holds its output while en is low.
module fft_twiddle_rom
   import fft_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] k,
   output tw_t        w
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  w <= '0;
      else if (en) w <= twiddle(k);
   end

endmodule

// File: rtl/fft_bfly_stage.sv
// Four-stage pipelined radix-2 DIT butterfly: X = A + B*W, Y = A - B*W, full precision.
module fft_bfly_stage
   import fft_pkg::*;
#(
   parameter int STAGE = 0,
   parameter int I     = 4,
   parameter int F     = 12,
   parameter int TW    = 16
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sof,
   input  logic [I+F-1:0]     a_re,
   input  logic [I+F-1:0]     a_im,
   input  logic [I+F-1:0]     b_re,
   input  logic [I+F-1:0]     b_im,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_sof,
   output logic [I+F+TW+1:0]  x_re,
   output logic [I+F+TW+1:0]  x_im,
   output logic [I+F+TW+1:0]  y_re,
   output logic [I+F+TW+1:0]  y_im,
   output logic               align_err
);

   localparam int DW     = I + F;
   localparam int PW     = DW + TW;
   localparam int OW     = DW + TW + 2;
   localparam int CW     = $clog2(N / 2);
   localparam int STAGES = 4;
   localparam logic [CW-1:0] KMASK = CW'((1 << STAGE) - 1);
   localparam int KSH = CW - STAGE;

   logic                 en;
   logic [STAGES:1]      vld_pipe;
   logic [STAGES:1]      sof_pipe;
   logic [CW-1:0]        cnt, c_eff, k;
   tw_t                  w;
   logic signed [TW-1:0] wr, wi;

   logic signed [DW-1:0] a1_re, a1_im, b1_re, b1_im;
   logic signed [DW-1:0] a2_re, a2_im;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [OW-1:0] a3_re, a3_im;
   logic signed [PW:0]   p_re, p_im;
   logic signed [OW-1:0] x_re_q, x_im_q, y_re_q, y_im_q;

   // The whole pipeline stalls as one unit whenever a held result is not taken.
   assign en       = !vld_pipe[STAGES] || out_ready;
   assign in_ready = en;

   assign c_eff = in_sof ? '0 : cnt;
   assign k     = (c_eff & KMASK) << KSH;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         align_err <= 1'b0;
      end else if (in_valid && en) begin
         cnt <= in_sof ? CW'(1) : cnt + CW'(1);
         if (in_sof && cnt != '0) align_err <= 1'b1;
      end
   end

   fft_twiddle_rom u_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .k     (k),
      .w     (w)
   );

   assign wr = TW'(w.re);
   assign wi = TW'(w.im);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         sof_pipe <= '0;
         a1_re <= '0; a1_im <= '0; b1_re <= '0; b1_im <= '0;
         a2_re <= '0; a2_im <= '0;
         p_rr  <= '0; p_ii  <= '0; p_ri  <= '0; p_ir  <= '0;
         a3_re <= '0; a3_im <= '0; p_re  <= '0; p_im  <= '0;
         x_re_q <= '0; x_im_q <= '0; y_re_q <= '0; y_im_q <= '0;
      end else if (en) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
         sof_pipe <= {sof_pipe[STAGES-1:1], in_valid && in_sof};
         // S1: operands (twiddle registered alongside in the ROM)
         a1_re <= a_re; a1_im <= a_im; b1_re <= b_re; b1_im <= b_im;
         // S2: partial products
         a2_re <= a1_re;
         a2_im <= a1_im;
         p_rr  <= PW'(b1_re) * PW'(wr);
         p_ii  <= PW'(b1_im) * PW'(wi);
         p_ri  <= PW'(b1_re) * PW'(wi);
         p_ir  <= PW'(b1_im) * PW'(wr);
         // S3: complex product, A brought onto the product's binary point
         p_re  <= (PW+1)'(p_rr) - (PW+1)'(p_ii);
         p_im  <= (PW+1)'(p_ri) + (PW+1)'(p_ir);
         a3_re <= OW'(a2_re) <<< TF;
         a3_im <= OW'(a2_im) <<< TF;
         // S4: butterfly sums
         x_re_q <= a3_re + OW'(p_re);
         x_im_q <= a3_im + OW'(p_im);
         y_re_q <= a3_re - OW'(p_re);
         y_im_q <= a3_im - OW'(p_im);
      end
   end

   assign out_valid = vld_pipe[STAGES];
   assign out_sof   = sof_pipe[STAGES];
   assign x_re      = x_re_q;
   assign x_im      = x_im_q;
   assign y_re      = y_re_q;
   assign y_im      = y_im_q;

endmodule

// File: tb/tb_fft_bfly_stage.sv
// Scoreboard bench: STAGE=4 and STAGE=2 butterflies run in lockstep on shared stimulus.
module tb_fft_bfly_stage;

   localparam real PI = 3.14159265358979323846;

   logic        clk, rst_n, in_valid, in_sof, out_ready;
   logic [15:0] a_re, a_im, b_re, b_im;
   logic        in_ready4, out_valid4, out_sof4, align_err4;
   logic        in_ready2, out_valid2, out_sof2, align_err2;
   logic [33:0] x4_re, x4_im, y4_re, y4_im;
   logic [33:0] x2_re, x2_im, y2_re, y2_im;

   typedef struct {
      longint x4r, x4i, y4r, y4i;
      longint x2r, x2i, y2r, y2i;
      logic   sof;
      int     t_in;
   } exp_t;

   exp_t q[$];
   int   ntests, nfail, cyc, mcnt;
   int   cur_ar, cur_ai, cur_br, cur_bi;
   logic merr;
   bit   bp, last_in_x;

   fft_bfly_stage #(.STAGE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_sof(in_sof),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .out_valid(out_valid4), .out_ready(out_ready), .out_sof(out_sof4),
      .x_re(x4_re), .x_im(x4_im), .y_re(y4_re), .y_im(y4_im), .align_err(align_err4));

   fft_bfly_stage #(.STAGE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_sof(in_sof),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .out_valid(out_valid2), .out_ready(out_ready), .out_sof(out_sof2),
      .x_re(x2_re), .x_im(x2_im), .y_re(y2_re), .y_im(y2_im), .align_err(align_err2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint rnd(input real v);
      return (v < 0.0) ? longint'($rtoi(v - 0.5)) : longint'($rtoi(v + 0.5));
   endfunction

   function automatic longint wre(input int k);
      return rnd(16384.0 * $cos(2.0 * PI * k / 32.0));
   endfunction

   function automatic longint wim(input int k);
      return -rnd(16384.0 * $sin(2.0 * PI * k / 32.0));
   endfunction

   task automatic bfly(input longint ar, input longint ai, input longint br, input longint bi,
                       input int k, output longint xr, output longint xi,
                       output longint yr, output longint yi);
      longint pr, pim;
      pr  = br * wre(k) - bi * wim(k);
      pim = br * wim(k) + bi * wre(k);
      xr  = ar * 16384 + pr;
      xi  = ai * 16384 + pim;
      yr  = ar * 16384 - pr;
      yi  = ai * 16384 - pim;
   endtask

   task automatic chk(input string tag, input longint obs, input longint exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: check outputs and handshake before the edge, score transfers, advance.
   task automatic step();
      exp_t e;
      int   c;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("in_ready", in_ready4, !out_valid4 || out_ready);
      chk("in_ready_s2", in_ready2, in_ready4);
      chk("out_valid_s2", out_valid2, out_valid4);
      chk("align_err", align_err4, merr);
      chk("align_err_s2", align_err2, merr);
      chk("cnt", dut4.cnt, mcnt);
      last_in_x = in_valid && in_ready4;
      if (out_valid4 && out_ready) begin
         chk("out_pending", q.size() > 0, 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("x_re", $signed(x4_re), e.x4r);
            chk("x_im", $signed(x4_im), e.x4i);
            chk("y_re", $signed(y4_re), e.y4r);
            chk("y_im", $signed(y4_im), e.y4i);
            chk("x_re_s2", $signed(x2_re), e.x2r);
            chk("x_im_s2", $signed(x2_im), e.x2i);
            chk("y_re_s2", $signed(y2_re), e.y2r);
            chk("y_im_s2", $signed(y2_im), e.y2i);
            chk("out_sof", out_sof4, e.sof);
            chk("out_sof_s2", out_sof2, e.sof);
            if (!bp) chk("latency", cyc - e.t_in, 4);
         end
      end
      if (last_in_x) begin
         c = in_sof ? 0 : mcnt;
         bfly(cur_ar, cur_ai, cur_br, cur_bi, c, e.x4r, e.x4i, e.y4r, e.y4i);
         bfly(cur_ar, cur_ai, cur_br, cur_bi, (c & 3) << 2, e.x2r, e.x2i, e.y2r, e.y2i);
         e.sof  = in_sof;
         e.t_in = cyc;
         q.push_back(e);
         if (in_sof && mcnt != 0) merr = 1'b1;
         mcnt = in_sof ? 1 : (mcnt + 1) % 16;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input int ar, input int ai, input int br, input int bi, input bit sof);
      cur_ar = ar; cur_ai = ai; cur_br = br; cur_bi = bi;
      a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
      in_sof   = sof;
      in_valid = 1'b1;
      for (int t = 0; t < 64; t++) begin
         step();
         if (last_in_x) break;
      end
      chk("send_accepted", last_in_x, 1);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      for (int t = 0; t < 300 && q.size() > 0; t++) step();
      chk("drain_empty", q.size(), 0);
      repeat (2) step();
   endtask

   // Async reset applied between edges; state must clear without waiting for a clock.
   task automatic do_reset();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid4, 0);
      chk("rst_out_valid_s2", out_valid2, 0);
      chk("rst_in_ready", in_ready4, 1);
      chk("rst_cnt", dut4.cnt, 0);
      chk("rst_align_err", align_err4, 0);
      chk("rst_out_sof", out_sof4, 0);
      chk("rst_x_re", x4_re, 0);
      chk("rst_y_im", y4_im, 0);
      q.delete();
      mcnt = 0;
      merr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   function automatic int rnd16();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   initial begin
      ntests = 0; nfail = 0; cyc = 0; mcnt = 0; merr = 1'b0; bp = 1'b0; last_in_x = 1'b0;
      rst_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
      a_re = '0; a_im = '0; b_re = '0; b_im = '0;
      cur_ar = 0; cur_ai = 0; cur_br = 0; cur_bi = 0;
      @(posedge clk);
      #1;
      do_reset();

      // basic: A=B=1.0, k=0 -> X=2.0<<26, Y=0, 4-cycle latency
      send(4096, 0, 4096, 0, 1'b1);
      drain();
      do_reset();

      // full frame, B=1.0: walks every twiddle on STAGE 4, stride 4 on STAGE 2
      for (int i = 0; i < 16; i++) send(0, 0, 4096, 0, i == 0);
      drain();

      // extremes at k=0 and k=8 plus most-positive operands at k=4
      for (int i = 0; i < 16; i++) begin
         if (i == 0 || i == 8)  send(-32768, -32768, -32768, -32768, i == 0);
         else if (i == 4)       send(32767, 32767, 32767, 32767, 1'b0);
         else                   send(rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
      end
      drain();

      // random backpressure and bubbles over 64 pairs
      bp = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            step();
         end
         send(rnd16(), rnd16(), rnd16(), rnd16(), (i % 16) == 0);
      end
      drain();
      bp = 1'b0;

      // misaligned sof at cnt=5; following pair continues from 1
      for (int i = 0; i < 5; i++) send(rnd16(), rnd16(), 4096, 2048, i == 0);
      send(1000, -1000, 4096, 2048, 1'b1);
      for (int i = 0; i < 3; i++) send(rnd16(), rnd16(), 4096, 2048, 1'b0);
      drain();
      chk("align_sticky", align_err4, 1);

      // reset with three pairs in flight, then a clean frame
      send(100, 200, 300, 400, 1'b1);
      send(500, 600, 700, 800, 1'b0);
      send(900, 1000, 1100, 1200, 1'b0);
      do_reset();
      for (int i = 0; i < 16; i++) send(rnd16(), rnd16(), 4096, -4096, i == 0);
      drain();
      chk("align_clear", align_err4, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
